// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: builds decimal operands A and B from keypad events, writes
// A/op/B to the shared number memory, runs the processor and shows its result.
// Optional build macro CALC_TIMEOUT_EN: bounds the wait for proc_done and adds ERR.
module calc_op_sequencer #(
    parameter int unsigned MAX_DIGITS = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_digit,
    input  logic [3:0]  digit,
    input  logic        new_op,
    input  logic [3:0]  op_code,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        proc_start,
    input  logic        proc_done,
    input  logic [31:0] proc_result,
    output logic [31:0] num_actual,
    output logic [3:0]  digit_count,
    output logic        result_valid,
    output logic        busy,
    output logic        error
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam logic [3:0] OP_EQ  = 4'hF;
    localparam logic [3:0] OP_CLR = 4'hE;

    typedef enum logic [3:0] {
        S_ENTER_A, S_ENTER_B, S_WR_A, S_WR_OP, S_WR_B, S_START, S_WAIT, S_SHOW, S_ERR
    } state_t;

    // Reject operand sizes that cannot be held in 32 bits or a zero timeout.
    if (MAX_DIGITS == 0 || MAX_DIGITS > 9 || TIMEOUT == 0) begin : g_param_check
        $error("calc_op_sequencer: MAX_DIGITS must be 1..9 and TIMEOUT nonzero");
    end

    state_t        state, state_nxt;
    logic [DW-1:0] acc, acc_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] opa, opa_nxt;
    logic [3:0]    opc, opc_nxt;
    logic [DW-1:0] opb, opb_nxt;
    logic [DW-1:0] res, res_nxt;
    logic          do_clear, load_first;

    logic [DW-1:0] mem_addr_nxt, mem_wdata_nxt, num_actual_nxt;
    logic          mem_we_nxt, proc_start_nxt, result_valid_nxt, busy_nxt, error_nxt;

`ifdef CALC_TIMEOUT_EN
    logic [DW-1:0] wcnt, wcnt_nxt;
`endif

    logic is_eq_c, is_clr_c, is_arith_c, dig_ok_c;
    assign is_eq_c    = new_op && (op_code == OP_EQ);
    assign is_clr_c   = new_op && (op_code == OP_CLR);
    assign is_arith_c = new_op && !is_eq_c && !is_clr_c;
    assign dig_ok_c   = new_digit && !new_op && (digit <= 4'd9) && (cnt < CW'(MAX_DIGITS));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_ENTER_A;
        else        state <= state_nxt;
    end

    // Next state and operand datapath
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        opa_nxt    = opa;
        opc_nxt    = opc;
        opb_nxt    = opb;
        res_nxt    = res;
        do_clear   = 1'b0;
        load_first = 1'b0;
`ifdef CALC_TIMEOUT_EN
        wcnt_nxt   = wcnt;
`endif
        case (state)
            S_ENTER_A: begin
                if (is_clr_c) begin
                    do_clear = 1'b1;
                end else if (is_arith_c && cnt != '0) begin
                    opa_nxt   = acc;
                    opc_nxt   = op_code;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = S_ENTER_B;
                end else if (dig_ok_c) begin
                    acc_nxt = DW'(acc * 32'd10) + DW'(digit);
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_ENTER_B: begin
                if (is_clr_c) begin
                    do_clear = 1'b1;
                end else if (is_eq_c) begin
                    if (cnt != '0) begin
                        opb_nxt   = acc;
                        state_nxt = S_WR_A;
                    end
                end else if (is_arith_c) begin
                    opc_nxt = op_code;
                end else if (dig_ok_c) begin
                    acc_nxt = DW'(acc * 32'd10) + DW'(digit);
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_WR_A:  state_nxt = S_WR_OP;
            S_WR_OP: state_nxt = S_WR_B;
            S_WR_B:  state_nxt = S_START;
            S_START: begin
                state_nxt = S_WAIT;
`ifdef CALC_TIMEOUT_EN
                wcnt_nxt  = '0;
`endif
            end
            S_WAIT: begin
                if (proc_done) begin
                    res_nxt   = proc_result;
                    state_nxt = S_SHOW;
                end
`ifdef CALC_TIMEOUT_EN
                else if (wcnt == DW'(TIMEOUT - 1)) begin
                    state_nxt = S_ERR;
                end else begin
                    wcnt_nxt = wcnt + DW'(1);
                end
`endif
            end
            S_SHOW: begin
                if (is_clr_c) begin
                    do_clear = 1'b1;
                end else if (is_arith_c) begin
                    opa_nxt   = res;
                    opc_nxt   = op_code;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = S_ENTER_B;
                end else if (new_digit && !new_op && digit <= 4'd9) begin
                    do_clear   = 1'b1;
                    load_first = 1'b1;
                end
            end
            S_ERR: begin
                if (is_clr_c) do_clear = 1'b1;
            end
            default: state_nxt = S_ENTER_A;
        endcase

        if (do_clear) begin
            state_nxt = S_ENTER_A;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            opa_nxt   = '0;
            opc_nxt   = '0;
            opb_nxt   = '0;
            res_nxt   = '0;
        end
        if (load_first) begin
            acc_nxt = DW'(digit);
            cnt_nxt = CW'(1);
        end
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        mem_we_nxt       = 1'b0;
        mem_addr_nxt     = '0;
        mem_wdata_nxt    = '0;
        proc_start_nxt   = 1'b0;
        busy_nxt         = 1'b0;
        result_valid_nxt = 1'b0;
        error_nxt        = 1'b0;
        num_actual_nxt   = acc_nxt;
        case (state_nxt)
            S_WR_A: begin
                mem_we_nxt    = 1'b1;
                mem_addr_nxt  = BASE_ADDR;
                mem_wdata_nxt = opa_nxt;
                busy_nxt      = 1'b1;
            end
            S_WR_OP: begin
                mem_we_nxt    = 1'b1;
                mem_addr_nxt  = BASE_ADDR + 32'd4;
                mem_wdata_nxt = {28'b0, opc_nxt};
                busy_nxt      = 1'b1;
            end
            S_WR_B: begin
                mem_we_nxt    = 1'b1;
                mem_addr_nxt  = BASE_ADDR + 32'd8;
                mem_wdata_nxt = opb_nxt;
                busy_nxt      = 1'b1;
            end
            S_START: begin
                proc_start_nxt = 1'b1;
                busy_nxt       = 1'b1;
            end
            S_WAIT: busy_nxt = 1'b1;
            S_SHOW: begin
                result_valid_nxt = 1'b1;
                num_actual_nxt   = res_nxt;
            end
            S_ERR: begin
                num_actual_nxt = '0;
`ifdef CALC_TIMEOUT_EN
                error_nxt      = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Operand registers and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc          <= '0;
            cnt          <= '0;
            opa          <= '0;
            opc          <= '0;
            opb          <= '0;
            res          <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            proc_start   <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            num_actual   <= '0;
            digit_count  <= '0;
        end else begin
            acc          <= acc_nxt;
            cnt          <= cnt_nxt;
            opa          <= opa_nxt;
            opc          <= opc_nxt;
            opb          <= opb_nxt;
            res          <= res_nxt;
            mem_we       <= mem_we_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_wdata    <= mem_wdata_nxt;
            proc_start   <= proc_start_nxt;
            busy         <= busy_nxt;
            result_valid <= result_valid_nxt;
            error        <= error_nxt;
            num_actual   <= num_actual_nxt;
            digit_count  <= cnt_nxt;
        end
    end

`ifdef CALC_TIMEOUT_EN
    // Cycles spent waiting for the processor
    always_ff @(posedge clk) begin
        if (!reset) wcnt <= '0;
        else        wcnt <= wcnt_nxt;
    end
`endif

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: operands are random decimal values typed in digit
// by digit; expected memory writes, timing and display are derived from them.
module tb_calc_op_sequencer;

    localparam int unsigned TB_TIMEOUT =
`ifdef CALC_TIMEOUT_EN
        10;
`else
        1023;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        new_digit;
    logic [3:0]  digit;
    logic        new_op;
    logic [3:0]  op_code;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        proc_start;
    logic        proc_done;
    logic [31:0] proc_result;
    logic [31:0] num_actual;
    logic [3:0]  digit_count;
    logic        result_valid;
    logic        busy;
    logic        error;

    calc_op_sequencer #(.MAX_DIGITS(8), .BASE_ADDR(32'h0), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .new_digit(new_digit), .digit(digit),
        .new_op(new_op), .op_code(op_code),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .proc_start(proc_start), .proc_done(proc_done), .proc_result(proc_result),
        .num_actual(num_actual), .digit_count(digit_count),
        .result_valid(result_valid), .busy(busy), .error(error)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int          w_cyc[$];
    logic [31:0] w_addr[$];
    logic [31:0] w_data[$];
    int          s_cyc[$];

    // Record every memory write and processor start with its cycle number
    always @(negedge clk) begin
        if (mem_we) begin
            w_cyc.push_back(cyc);
            w_addr.push_back(mem_addr);
            w_data.push_back(mem_wdata);
        end
        if (proc_start) s_cyc.push_back(cyc);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input logic [3:0] d);
        new_digit = 1'b1;
        digit     = d;
        tick();
        new_digit = 1'b0;
    endtask

    task automatic send_op(input logic [3:0] c);
        new_op  = 1'b1;
        op_code = c;
        tick();
        new_op  = 1'b0;
    endtask

    task automatic pulse_done(input logic [31:0] r);
        proc_done   = 1'b1;
        proc_result = r;
        tick();
        proc_done   = 1'b0;
        proc_result = '0;
    endtask

    task automatic clear_log();
        w_cyc.delete();
        w_addr.delete();
        w_data.delete();
        s_cyc.delete();
    endtask

    function automatic logic [31:0] pow10(input int k);
        logic [31:0] p = 32'd1;
        for (int i = 0; i < k; i++) p = p * 32'd10;
        return p;
    endfunction

    // Type value v as exactly n decimal digits, most significant first
    task automatic send_number(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) send_digit(4'((v / pow10(n - 1 - i)) % 32'd10));
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_we, proc_start, num_actual, digit_count,
             result_valid, busy, error} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got addr=%0h data=%0h we=%b st=%b num=%0d cnt=%0d rv=%b busy=%b err=%b expected all 0",
                     mem_addr, mem_wdata, mem_we, proc_start, num_actual, digit_count, result_valid, busy, error);
        end
    endtask

    // Full calculation from a cleared state; dly = idle WAIT cycles before proc_done
    task automatic run_calc(input logic [31:0] a, input int na, input logic [3:0] opc,
                            input logic [31:0] b, input int nb, input logic [31:0] r,
                            input int dly, input string tag);
        int c0;
        logic [31:0] ed[3];
        send_op(4'hE);
        send_number(a, na);
        n_cmp++;
        if (num_actual !== a || digit_count !== 4'(na)) begin
            n_bad++;
            $display("FAIL %s_entry_a: got num=%0d cnt=%0d expected num=%0d cnt=%0d", tag, num_actual, digit_count, a, na);
        end
        send_op(opc);
        n_cmp++;
        if (num_actual !== 32'd0 || digit_count !== 4'd0) begin
            n_bad++;
            $display("FAIL %s_after_op: got num=%0d cnt=%0d expected 0 0", tag, num_actual, digit_count);
        end
        send_number(b, nb);
        n_cmp++;
        if (num_actual !== b || digit_count !== 4'(nb)) begin
            n_bad++;
            $display("FAIL %s_entry_b: got num=%0d cnt=%0d expected num=%0d cnt=%0d", tag, num_actual, digit_count, b, nb);
        end
        clear_log();
        c0 = cyc;
        send_op(4'hF);
        repeat (4) tick();
        n_cmp++;
        if (busy !== 1'b1 || proc_start !== 1'b0 || result_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_wait: got busy=%b start=%b rv=%b expected 1 0 0", tag, busy, proc_start, result_valid);
        end
        repeat (dly) tick();
        pulse_done(r);
        n_cmp++;
        if (result_valid !== 1'b1 || num_actual !== r || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_result: got rv=%b num=%0d busy=%b expected rv=1 num=%0d busy=0", tag, result_valid, num_actual, busy, r);
        end
        ed[0] = a;
        ed[1] = {28'b0, opc};
        ed[2] = b;
        n_cmp++;
        if (w_cyc.size() != 3) begin
            n_bad++;
            $display("FAIL %s_write_count: got %0d expected 3", tag, w_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (w_addr[i] !== 32'(4 * i) || w_data[i] !== ed[i] || w_cyc[i] !== c0 + 1 + i) begin
                    n_bad++;
                    $display("FAIL %s_write%0d: got addr=%0d data=%0d cyc=%0d expected addr=%0d data=%0d cyc=%0d",
                             tag, i, w_addr[i], w_data[i], w_cyc[i], 4 * i, ed[i], c0 + 1 + i);
                end
            end
        end
        n_cmp++;
        if (s_cyc.size() != 1 || s_cyc[0] !== c0 + 4) begin
            n_bad++;
            $display("FAIL %s_start: got %0d pulses first_cyc=%0d expected 1 at %0d", tag, s_cyc.size(),
                     (s_cyc.size() > 0) ? s_cyc[0] : -1, c0 + 4);
        end
    endtask

    task automatic test_basic();
        run_calc(32'd12, 2, 4'h1, 32'd7, 1, 32'd19, 2, "basic");
    endtask

    task automatic test_chaining();
        int c0;
        send_op(4'h2);
        n_cmp++;
        if (num_actual !== 32'd0 || digit_count !== 4'd0 || result_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL chain_op: got num=%0d cnt=%0d rv=%b expected 0 0 0", num_actual, digit_count, result_valid);
        end
        send_digit(4'd3);
        clear_log();
        c0 = cyc;
        send_op(4'hF);
        repeat (4) tick();
        pulse_done(32'd17);
        n_cmp++;
        if (w_cyc.size() != 3) begin
            n_bad++;
            $display("FAIL chain_write_count: got %0d expected 3", w_cyc.size());
        end else begin
            n_cmp++;
            if (w_data[0] !== 32'd19 || w_data[1] !== 32'd2 || w_data[2] !== 32'd3 ||
                w_addr[2] !== 32'd8 || w_cyc[0] !== c0 + 1) begin
                n_bad++;
                $display("FAIL chain_writes: got A=%0d op=%0d B=%0d expected 19 2 3", w_data[0], w_data[1], w_data[2]);
            end
        end
        n_cmp++;
        if (result_valid !== 1'b1 || num_actual !== 32'd17) begin
            n_bad++;
            $display("FAIL chain_result: got rv=%b num=%0d expected 1 17", result_valid, num_actual);
        end
    endtask

    task automatic test_show_digit();
        send_digit(4'd6);
        n_cmp++;
        if (num_actual !== 32'd6 || digit_count !== 4'd1 || result_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL show_digit: got num=%0d cnt=%0d rv=%b expected 6 1 0", num_actual, digit_count, result_valid);
        end
    endtask

    task automatic test_digit_limit();
        send_op(4'hE);
        repeat (9) send_digit(4'd9);
        n_cmp++;
        if (num_actual !== 32'd99999999 || digit_count !== 4'd8) begin
            n_bad++;
            $display("FAIL digit_limit: got num=%0d cnt=%0d expected 99999999 8", num_actual, digit_count);
        end
    endtask

    task automatic test_ignored();
        int c0;
        send_op(4'hE);
        send_digit(4'd3);
        send_digit(4'hA);
        send_digit(4'hF);
        n_cmp++;
        if (num_actual !== 32'd3 || digit_count !== 4'd1) begin
            n_bad++;
            $display("FAIL bad_digit: got num=%0d cnt=%0d expected 3 1", num_actual, digit_count);
        end
        clear_log();
        send_op(4'hF);
        tick();
        n_cmp++;
        if (num_actual !== 32'd3 || busy !== 1'b0 || w_cyc.size() != 0) begin
            n_bad++;
            $display("FAIL eq_in_a: got num=%0d busy=%b writes=%0d expected 3 0 0", num_actual, busy, w_cyc.size());
        end
        send_op(4'hE);
        send_digit(4'd5);
        new_digit = 1'b1; digit = 4'd7; new_op = 1'b1; op_code = 4'h1;
        tick();
        new_digit = 1'b0; new_op = 1'b0;
        n_cmp++;
        if (num_actual !== 32'd0 || digit_count !== 4'd0) begin
            n_bad++;
            $display("FAIL simultaneous: got num=%0d cnt=%0d expected 0 0", num_actual, digit_count);
        end
        clear_log();
        send_op(4'hF);
        pulse_done(32'd555);
        repeat (4) tick();
        n_cmp++;
        if (w_cyc.size() != 0 || s_cyc.size() != 0 || busy !== 1'b0 || result_valid !== 1'b0 || num_actual !== 32'd0) begin
            n_bad++;
            $display("FAIL empty_b_eq: got writes=%0d starts=%0d busy=%b rv=%b num=%0d expected 0 0 0 0 0",
                     w_cyc.size(), s_cyc.size(), busy, result_valid, num_actual);
        end
        send_digit(4'd2);
        c0 = cyc;
        send_op(4'hF);
        repeat (4) tick();
        pulse_done(32'd123);
        n_cmp++;
        if (w_cyc.size() != 3) begin
            n_bad++;
            $display("FAIL simult_write_count: got %0d expected 3", w_cyc.size());
        end else begin
            n_cmp++;
            if (w_data[0] !== 32'd5 || w_data[1] !== 32'd1 || w_data[2] !== 32'd2 || w_cyc[0] !== c0 + 1) begin
                n_bad++;
                $display("FAIL simult_writes: got A=%0d op=%0d B=%0d expected 5 1 2", w_data[0], w_data[1], w_data[2]);
            end
        end
    endtask

    task automatic test_random();
        int na, nb, dly;
        logic [31:0] a, b, r;
        logic [3:0] opc;
        for (int k = 0; k < 6; k++) begin
            na  = $urandom_range(1, 8);
            nb  = $urandom_range(1, 8);
            a   = $urandom_range(0, pow10(na) - 1);
            b   = $urandom_range(0, pow10(nb) - 1);
            opc = 4'($urandom_range(0, 13));
            r   = $urandom;
            dly = $urandom_range(0, 6);
            run_calc(a, na, opc, b, nb, r, dly, $sformatf("rand%0d", k));
        end
    endtask

    task automatic test_reset_busy();
        send_op(4'hE);
        send_digit(4'd4);
        send_op(4'h3);
        send_digit(4'd5);
        clear_log();
        send_op(4'hF);
        tick();
        reset = 1'b0;
        tick();
        test_reset();
        reset = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (w_cyc.size() != 2 || s_cyc.size() != 0 || busy !== 1'b0 || num_actual !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_in_write: got writes=%0d starts=%0d busy=%b num=%0d expected 2 0 0 0",
                     w_cyc.size(), s_cyc.size(), busy, num_actual);
        end
        send_digit(4'd8);
        n_cmp++;
        if (num_actual !== 32'd8 || digit_count !== 4'd1) begin
            n_bad++;
            $display("FAIL after_reset_digit: got num=%0d cnt=%0d expected 8 1", num_actual, digit_count);
        end
    endtask

    task automatic test_clear_wait();
        send_op(4'hE);
        send_digit(4'd4);
        send_op(4'h1);
        send_digit(4'd4);
        send_op(4'hF);
        repeat (4) tick();
        send_op(4'hE);
        n_cmp++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_in_wait: got busy=%b rv=%b expected 1 0", busy, result_valid);
        end
        pulse_done(32'd8);
        n_cmp++;
        if (result_valid !== 1'b1 || num_actual !== 32'd8) begin
            n_bad++;
            $display("FAIL wait_result: got rv=%b num=%0d expected 1 8", result_valid, num_actual);
        end
        send_op(4'hE);
        n_cmp++;
        if (result_valid !== 1'b0 || num_actual !== 32'd0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_in_show: got rv=%b num=%0d busy=%b expected 0 0 0", result_valid, num_actual, busy);
        end
    endtask

`ifdef CALC_TIMEOUT_EN
    task automatic test_timeout();
        send_op(4'hE);
        send_digit(4'd1);
        send_op(4'h1);
        send_digit(4'd1);
        send_op(4'hF);
        repeat (4) tick();
        repeat (9) tick();
        n_cmp++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_early: got err=%b busy=%b expected 0 1", error, busy);
        end
        tick();
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0 || num_actual !== 32'd0) begin
            n_bad++;
            $display("FAIL timeout_err: got err=%b busy=%b num=%0d expected 1 0 0", error, busy, num_actual);
        end
        send_digit(4'd5);
        n_cmp++;
        if (error !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got err=%b expected 1", error);
        end
        send_op(4'hE);
        n_cmp++;
        if (error !== 1'b0 || busy !== 1'b0 || num_actual !== 32'd0 || digit_count !== 4'd0) begin
            n_bad++;
            $display("FAIL err_clear: got err=%b busy=%b num=%0d cnt=%0d expected 0 0 0 0", error, busy, num_actual, digit_count);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        new_digit   = 1'b0;
        digit       = '0;
        new_op      = 1'b0;
        op_code     = '0;
        proc_done   = 1'b0;
        proc_result = '0;
        tick();
        tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_basic();
        test_chaining();
        test_show_digit();
        test_digit_limit();
        test_ignored();
        test_random();
        test_reset_busy();
        test_clear_wait();
`ifdef CALC_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Sequencing controller for the calculator datapath, running on the 25 MHz divided clock. It takes the digit and operator events from the clicked-square decoder and builds operands A and B in decimal. It writes A, the opcode and B to the shared number memory, starts the processor, and waits for its result. It then presents the operand being entered, or the result, to the VGA painter and the result mux.

## Interface
Parameters:
- MAX_DIGITS, 8: maximum decimal digits per operand. Must be ≤ 9 so values fit in 32 bits.
- BASE_ADDR, 32'h0: memory word address of operand A. The opcode is at BASE_ADDR+4 and B at BASE_ADDR+8.
- TIMEOUT, 1023: maximum cycles to wait for proc_done. Used only with CALC_TIMEOUT_EN.

Ports (name, direction, width, meaning):
- clk  in  1  system clock (25 MHz domain).
- reset  in  1  synchronous, active-low reset.
- new_digit  in  1  one-cycle pulse: `digit` is valid.
- digit  in  4  decimal digit 0–9. Values above 9 are ignored.
- new_op  in  1  one-cycle pulse: `op_code` is valid.
- op_code  in  4  operator code. 4'hF means "equals", 4'hE means "clear", any other value is an arithmetic opcode.
- mem_addr  out  32  memory write address.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write enable, held for one cycle per write.
- proc_start  out  1  one-cycle pulse that starts the processor.
- proc_done  in  1  processor completion pulse.
- proc_result  in  32  processor result, valid when proc_done=1.
- num_actual  out  32  value to display: the operand being entered, or the result.
- digit_count  out  4  number of digits entered for the current operand.
- result_valid  out  1  high while in SHOW.
- busy  out  1  high in WR_A, WR_OP, WR_B, START and WAIT.
- error  out  1  high in ERR.

## Operation
States: ENTER_A, ENTER_B, WR_A, WR_OP, WR_B, START, WAIT, SHOW, ERR.

Transitions and actions:
- **Reset:** go to ENTER_A. All operand, opcode and count registers are cleared to 0. All outputs are 0.
- **Digit accept (ENTER_A / ENTER_B):** on new_digit with digit ≤ 9 and digit_count < MAX_DIGITS, update `acc = acc*10 + digit` (arithmetic modulo 2^32) and increment digit_count. Otherwise the event is dropped.
- **ENTER_A:**
  - new_op with an arithmetic code and digit_count > 0: latch A=acc and op=op_code, clear acc and digit_count, go to ENTER_B.
  - new_op with an arithmetic code and digit_count = 0: ignored.
  - "equals" in ENTER_A: ignored.
- **ENTER_B:**
  - "equals" with digit_count > 0: latch B=acc, go to WR_A.
  - Arithmetic op: replaces the latched op, with acc unchanged.
  - "equals" with digit_count = 0: ignored.
- **Write sequence** (mem_we=1 for exactly one cycle in each state):
  - WR_A: address BASE_ADDR, data A.
  - WR_OP: address BASE_ADDR+4, data {28'b0, op}.
  - WR_B: address BASE_ADDR+8, data B.
- **START:** proc_start=1 for one cycle, then go to WAIT.
- **WAIT:** on proc_done, latch proc_result and go to SHOW.
- **SHOW:**
  - num_actual shows the result.
  - new_digit: clear everything, load the digit as the first digit of A, go to ENTER_A.
  - Arithmetic op: A=result, op latched, go to ENTER_B. This chains calculations.
- **Clear (op_code 4'hE):** in ENTER_A, ENTER_B, SHOW or ERR, zero all registers and go to ENTER_A.
- **Busy states:** all new_digit and new_op events are ignored, including clear.
- **Simultaneous events:** if new_digit and new_op arrive in the same cycle, new_op wins and the digit is dropped.
- **num_actual:** equals acc in the ENTER states, the latched result in SHOW, and 0 in ERR.

## Timing
- A digit pulse in cycle n is visible on num_actual and digit_count in cycle n+1.
- For "equals" in cycle n:
  - WR_A in n+1, WR_OP in n+2, WR_B in n+3.
  - proc_start in n+4.
  - WAIT from n+5.
- proc_done in cycle d gives result_valid=1 and num_actual=result from cycle d+1.
- proc_done is only sampled in WAIT. A pulse arriving in any other state is ignored.
- All outputs are registered. Reset takes effect at the first clk edge with reset=0 and overrides any state, including a write sequence in progress.

## Configuration
- **CALC_TIMEOUT_EN defined:**
  - A wait counter starts at 0 on entry to WAIT and increments each cycle.
  - When it reaches TIMEOUT without proc_done, go to ERR with error=1.
  - ERR is left only by clear or reset.
- **CALC_TIMEOUT_EN undefined:** WAIT waits indefinitely, the counter is not built, and error is tied to 0.

## Test plan
- **Basic calculation:**
  - Stimulus: digits 1,2; op 4'h1; digit 7; "equals"; proc_done with result 19 three cycles after proc_start.
  - Required: writes (0,12), (4,1), (8,7) on consecutive cycles; one proc_start; result_valid=1 and num_actual=19.
- **Digit limit:** 9 digits of 9 with MAX_DIGITS=8 → num_actual=99999999 and digit_count=8; the ninth digit is ignored.
- **Ignored events:**
  - digit=4'hA: num_actual unchanged.
  - new_digit and new_op in the same cycle in ENTER_A with acc=5: op taken and A=5.
  - "equals" with no B digits: stays in ENTER_B, no mem_we.
- **Chaining:** in SHOW with result 19, op 4'h2, digit 3, "equals" → writes A=19, op=2, B=3.
- **Reset and busy behaviour:**
  - reset=0 during WR_OP: no further writes, state ENTER_A, all outputs 0.
  - clear during WAIT: ignored.
- **Timeout (CALC_TIMEOUT_EN, TIMEOUT=10):** no proc_done → error=1 exactly 10 cycles after WAIT entry; clear → ENTER_A with error=0.
